// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Writes a program into the instruction memory at boot time. The program
//   arrives as a byte stream over a valid/ready handshake. The loader holds
//   the processor in reset until the whole program is in memory.
//
//   Stream format:
//     1. A 16-bit word count, sent high byte first.
//     2. count x 4 data bytes.
//   Each group of four data bytes forms one big-endian instruction word.
//   The first byte of a group becomes wdata[31:24]. Words are written to
//   consecutive word addresses, starting at BASE_ADDR.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN):
//   When the macro is defined, one extra byte follows the last word (it is
//   also sent when count is 0). That byte must equal the XOR of all data
//   bytes; the count bytes are not included in the XOR.
//   - Match:    the load finishes in DONE.
//   - Mismatch: the load finishes in ERR.
//
// Parameters:
//   BASE_ADDR  byte address of the first word (must be word aligned)
//   MAX_WORDS  largest accepted word count (must be <= 65535)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   start         one-cycle pulse; starts a new load from DONE or ERR
//   in_data       stream byte
//   in_valid      in_data is valid
//   in_ready      loader can take a byte (registered)
//   imem_we       one-cycle instruction memory write strobe
//   imem_addr     instruction memory byte address
//   imem_wdata    instruction word to write
//   cpu_hold      1 = keep the processor in reset
//   done          load finished successfully
//   error         load aborted
//   words_loaded  number of words written in the current load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK
  } state_t;
  // State entered after the last word, or directly when count is 0.
  localparam state_t S_LAST = S_CHK;
`else
  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;
  localparam state_t S_LAST = S_DONE;
`endif

  // One extra bit so that a count of 65535 can never wrap in the compare.
  localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] words_q, words_d;
  logic        in_ready_q, in_ready_d;
  logic        we_q, we_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] len_full;

  // A byte is consumed only when in_ready was already asserted. in_ready is
  // registered, so a byte offered without in_ready has no effect.
  assign accept   = in_valid & in_ready_q;
  assign len_full = {count_q[15:8], in_data};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LEN_HI;
      count_q    <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      addr_q     <= BASE_ADDR;
      words_q    <= '0;
      in_ready_q <= 1'b1;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    words_d = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    case (state_q)
      S_LEN_HI: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        // Holding the accumulator at 0 while in LEN_HI clears it on every
        // entry to this state: after reset and after start.
        csum_d = '0;
`endif
        if (accept) begin
          count_d[15:8] = in_data;
          state_d       = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          count_d[7:0] = in_data;
          idx_d        = '0;
          if (len_full == 16'd0) begin
            state_d = S_LAST;
          end else if ({1'b0, len_full} > MAX_WORDS_W) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          // Shift left so that the first byte ends up in wdata[31:24].
          wdata_d = {wdata_q[23:0], in_data};
          idx_d   = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        // addr_q always equals BASE_ADDR + 4*words_q. Both advance together
        // at the end of the write cycle.
        words_d = words_q + 16'd1;
        addr_d  = addr_q + 32'd4;
        if (words_d == count_q) begin
          state_d = S_LAST;
        end else begin
          state_d = S_DATA;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif

      S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          words_d = '0;
          addr_d  = BASE_ADDR;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = S_LEN_HI;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs are decoded from the next state. The registered outputs therefore
  // line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready_d = 1'b0;
    we_d       = 1'b0;
    hold_d     = 1'b1;
    done_d     = 1'b0;
    error_d    = 1'b0;

    case (state_d)
      S_LEN_HI, S_LEN_LO, S_DATA: in_ready_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:                      in_ready_d = 1'b1;
`endif
      S_WRITE:                    we_d       = 1'b1;
      S_DONE: begin
        hold_d = 1'b0;
        done_d = 1'b1;
      end
      S_ERR:                      error_d    = 1'b1;
      default: begin
        in_ready_d = 1'b0;
      end
    endcase
  end

  assign in_ready     = in_ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  imem_loader #(
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  logic [7:0] two_word [10];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every write strobe pops one expected (addr, data) pair.
  always @(negedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      wr_t e;
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_write observed addr=%h data=%h expected no write", imem_addr, imem_wdata);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e.addr);
        check("wr_data", imem_wdata, e.data);
        $display("write addr=%h data=%h expected addr=%h data=%h", imem_addr, imem_wdata, e.addr, e.data);
      end
      check("ready_in_write", {31'd0, in_ready}, 32'd0);
    end
  end

  // Offer one byte. The byte is held until a clock edge on which in_ready
  // was high. With bp set, random idle gaps are inserted before the byte.
  task automatic send(input logic [7:0] b, input bit bp);
    int  n;
    bit  ok;
    n  = 0;
    ok = 0;
    if (bp) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("send_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_end", {31'd0, (done === 1'b1 || error === 1'b1)}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_two(input bit bp);
    exp_q.push_back('{addr: 32'h0000_0000, data: 32'h2008_0005});
    exp_q.push_back('{addr: 32'h0000_0004, data: 32'hAC01_0004});
    for (int i = 0; i < 10; i++) begin
      send(two_word[i], bp);
    end
  endtask

  task automatic check_done(input string tag, input logic [15:0] nwords);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_words"}, {16'd0, words_loaded}, {16'd0, nwords});
    check({tag, "_queue"}, exp_q.size(), 32'd0);
    $display("%s: done=%0d error=%0d words=%0d", tag, done, error, words_loaded);
  endtask

  task automatic check_error(input string tag);
    check({tag, "_error"}, {31'd0, error}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    $display("%s: done=%0d error=%0d hold=%0d", tag, done, error, cpu_hold);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
    $display("%s: ready=%0d hold=%0d words=%0d", tag, in_ready, cpu_hold, words_loaded);
  endtask

  initial begin
    two_word = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
    rst      = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset_wdata", imem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Two-word load
    load_two(1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h84, 1'b0);
`endif
    wait_end();
    check_done("two_word", 16'd2);

    // start from DONE
    pulse_start();
    check_idle("start_from_done");

    // Back-pressure load
    load_two(1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h84, 1'b1);
`endif
    wait_end();
    check_done("backpressure", 16'd2);

    // Oversize count
    pulse_start();
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    wait_end();
    check_error("oversize");
    pulse_start();
    check_idle("start_from_err");

    // Zero count
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00, 1'b0);
`endif
    wait_end();
    check_done("zero_count", 16'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h5A, 1'b0);
    wait_end();
    check_error("zero_count_bad_csum");

    pulse_start();
    load_two(1'b0);
    send(8'h85, 1'b0);
    wait_end();
    check_error("bad_csum");
    check("bad_csum_queue", exp_q.size(), 32'd0);
`endif

    // Reset mid-load: stop after the 2nd byte of word 1
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h20, 1'b0);
    send(8'h08, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_idle("mid_reset");
    check("mid_reset_wdata", imem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    load_two(1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h84, 1'b0);
`endif
    wait_end();
    check_done("after_reset", 16'd2);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
